// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor: FSM states, default
// probe width, halt pattern and the snapshot word index type.
package cpu_mon_pkg;

    localparam int MON_DW = 24;
    localparam logic [MON_DW-1:0] MON_HALT_PATTERN = 24'hE00000;

    typedef logic [1:0] word_idx_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DUMP   = 2'd2,
        ST_DONE   = 2'd3
    } mon_state_t;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Snapshot output port.
// out_valid/out_ready handshake: a word moves on a rising edge with both high.
// While out_valid is high and out_ready is low, out_idx and out_data hold.
interface cpu_run_monitor_if
    import cpu_mon_pkg::*;
#(
    parameter int DW = MON_DW
);
    logic          out_valid;
    logic          out_ready;
    word_idx_t     out_idx;
    logic [DW-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/cpu_run_monitor_sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous clear, async reset.
module mon_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Watches the CPU probe outputs for the halt pattern in reg6, snapshots the
// four memory words on halt (or timeout) and streams them out one by one.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int               DW           = MON_DW,
    parameter logic [DW-1:0]    HALT_PATTERN = MON_HALT_PATTERN,
    parameter int               SETTLE_CYC   = 4,
    parameter int               CNT_W        = 32,
    parameter logic [31:0]      TIMEOUT_CYC  = 32'd1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       mem0,
    input  logic [DW-1:0]       mem1,
    input  logic [DW-1:0]       mem2,
    input  logic [DW-1:0]       mem3,
    input  logic [DW-1:0]       reg6,
    cpu_run_monitor_if.master   out_bus,
    output logic                halted,
    output logic                timeout,
    output logic                done,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    chg_cnt,
    output mon_state_t          state_dbg
);

    // Compare in 64 bits so a narrow counter never aliases a large timeout.
    localparam logic [63:0] TO_LAST = (TIMEOUT_CYC == 32'd0) ? 64'd0
                                    : (64'(TIMEOUT_CYC) - 64'd1);

    mon_state_t    state_q, state_d;
    logic [3:0]    settle_q, settle_d;
    word_idx_t     idx_q, idx_d;
    logic [DW-1:0] snap_q [4];
    logic [DW-1:0] prev_q [4];
    logic [DW-1:0] mem_w  [4];
    logic          prev_valid_q;
    logic          halted_q, timeout_q, done_q;

    logic          count_en;
    logic          mem_changed;
    logic          halt_match;
    logic          timeout_hit;
    logic          capture;
    logic          set_halt;
    logic          set_timeout;
    logic          xfer;

    always_comb begin
        mem_w[0] = mem0;
        mem_w[1] = mem1;
        mem_w[2] = mem2;
        mem_w[3] = mem3;
    end

    assign count_en    = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign halt_match  = (reg6 == HALT_PATTERN);
    assign timeout_hit = (TIMEOUT_CYC != 32'd0) && (64'(cycle_cnt) == TO_LAST);
    assign xfer        = out_bus.out_valid && out_bus.out_ready;

    always_comb begin
        mem_changed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_w[i] != prev_q[i]) mem_changed = 1'b1;
        end
        mem_changed = mem_changed && prev_valid_q;
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        set_halt    = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d     = ST_DUMP;
                    set_timeout = 1'b1;
                    capture     = 1'b1;
                end else if (halt_match) begin
                    if (SETTLE_CYC == 1) begin
                        state_d  = ST_DUMP;
                        set_halt = 1'b1;
                        capture  = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = 4'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (timeout_hit) begin
                    state_d     = ST_DUMP;
                    settle_d    = 4'd0;
                    set_timeout = 1'b1;
                    capture     = 1'b1;
                end else if (!halt_match) begin
                    state_d  = ST_RUN;
                    settle_d = 4'd0;
                end else if ((settle_q + 4'd1) == 4'(SETTLE_CYC)) begin
                    state_d  = ST_DUMP;
                    settle_d = 4'd0;
                    set_halt = 1'b1;
                    capture  = 1'b1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_DUMP: begin
                if (xfer) begin
                    if (idx_q == 2'd3) state_d = ST_DONE;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            settle_q     <= 4'd0;
            idx_q        <= '0;
            prev_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            if (count_en) begin
                prev_valid_q <= 1'b1;
                for (int i = 0; i < 4; i++) prev_q[i] <= mem_w[i];
            end
            if (capture) begin
                for (int i = 0; i < 4; i++) snap_q[i] <= mem_w[i];
            end
            if (set_halt)    halted_q  <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            // done follows one edge behind entry into DONE
            if (state_q == ST_DONE) done_q <= 1'b1;
        end
    end

    mon_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (count_en),
        .clr_i (1'b0),
        .cnt_o (cycle_cnt)
    );

    mon_sat_counter #(.CNT_W(CNT_W)) u_chg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (count_en && mem_changed),
        .clr_i (1'b0),
        .cnt_o (chg_cnt)
    );

    assign out_bus.out_valid = (state_q == ST_DUMP);
    assign out_bus.out_idx   = idx_q;
    assign out_bus.out_data  = snap_q[idx_q];
    assign halted            = halted_q;
    assign timeout           = timeout_q;
    assign done              = done_q;
    assign state_dbg         = state_q;

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run-control and result-capture stage sitting directly downstream of the 24-bit CPU top.
- Consumes the architectural probe outputs (mem0..mem3, reg6) and detects program halt, i.e. reg6 holding the halt pattern.
- On halt, snapshots the four memory words, then streams them out over a valid/ready port. Also counts run cycles and memory-change events, replacing the bench-side $monitor with hardware.

Parameters:
- DW, 24, data width of probe words.
- HALT_PATTERN, 24'hE00000, reg6 value that signals program end.
- SETTLE_CYC, 4, consecutive cycles reg6 must equal HALT_PATTERN before halt is accepted (1..15).
- CNT_W, 32, width of cycle and change counters.
- TIMEOUT_CYC, 32'd1_000_000, run cycles before timeout is declared (0 disables).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem0  in  DW  CPU memory word 0 probe.
- mem1  in  DW  CPU memory word 1 probe.
- mem2  in  DW  CPU memory word 2 probe.
- mem3  in  DW  CPU memory word 3 probe.
- reg6  in  DW  CPU register 6 probe (halt flag register).
- out_valid  out  1  snapshot word available.
- out_ready  in  1  consumer accepts word.
- out_idx  out  2  index of word on out_data.
- out_data  out  DW  snapshot word.
- halted  out  1  halt accepted (sticky until reset).
- timeout  out  1  timeout reached without halt (sticky).
- done  out  1  dump finished (after halt or timeout).
- cycle_cnt  out  CNT_W  cycles spent in RUN/SETTLE.
- chg_cnt  out  CNT_W  cycles in RUN/SETTLE where any memN differed from its previous-cycle value.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, all outputs 0, counters 0, settle counter 0, previous-mem registers 0.
- The first cycle after reset deassertion does not count as a change (prev_valid flag). Subsequent resets behave identically, so a rst_n 1->0->1 pulse restarts fully.
- State RUN:
  - cycle_cnt increments every cycle, saturating at all-ones.
  - chg_cnt increments (saturating) when prev_valid and any memN differs from its prev copy.
  - When reg6==HALT_PATTERN, go to SETTLE with settle counter = 1.
  - If TIMEOUT_CYC!=0 and cycle_cnt==TIMEOUT_CYC-1, go to DUMP with timeout=1. Timeout has priority over halt detection in the same cycle.
- State SETTLE:
  - Counting continues as in RUN.
  - If reg6!=HALT_PATTERN, return to RUN and clear the settle counter.
  - Else the counter increments. When it reaches SETTLE_CYC, go to DUMP, set halted=1, and capture mem0..mem3 into the snapshot registers in that same edge.
  - If SETTLE_CYC==1, halt is accepted on the first matching edge directly from RUN; RUN skips SETTLE.
- On timeout, the snapshot is captured at the timeout edge.
- State DUMP:
  - Counters frozen. out_valid=1, out_idx=k, out_data=snap[k], with k starting at 0.
  - A transfer occurs when out_valid&&out_ready at a rising edge; k then increments.
  - After the transfer with k==3, go to DONE.
  - out_data and out_idx hold stable while out_valid=1 and out_ready=0.
- State DONE: out_valid=0, done=1. Remains in DONE until reset; probe inputs are ignored.
- Latency: halt accepted SETTLE_CYC edges after reg6 first matches. First out_valid is asserted the cycle after acceptance. With out_ready held high, the minimum dump is 4 cycles and done rises on the edge after the 4th transfer.
- Reset mid-DUMP: dump aborts, out_valid drops immediately (asynchronous), snapshot is lost.
- All comparisons are full DW-bit equality; counters never wrap.

Decomposition:
- Shared package cpu_mon_pkg: state enum (RUN, SETTLE, DUMP, DONE), DW default, HALT_PATTERN constant, probe-word index type (2-bit).
- One natural sub-module: mon_sat_counter (CNT_W, enable, synchronous clear, async reset, saturating). Instantiated twice, for cycle_cnt and chg_cnt.

Test Plan:
- Basic halt: mem words change at cycles 5,9,9,20, reg6=E00000 from cycle 30 with out_ready=1 -> halted at cycle 33 (SETTLE_CYC=4), chg_cnt=3, cycle_cnt=33, out words idx 0..3 match mem values at cycle 33, done at cycle 38.
- Glitch reject: reg6=E00000 for 2 cycles, then 0, then steady from cycle 50 -> no halt at first pulse; halted only at cycle 53.
- Backpressure: out_ready low for 5 cycles at idx=1 and random thereafter -> out_data/out_idx stable while stalled, exactly 4 transfers in order 0,1,2,3, no duplicates.
- Timeout: TIMEOUT_CYC=100, reg6 never matches -> timeout=1, halted=0 after 100 cycles, snapshot dumped, done=1.
- Reset pulse: rst_n 1->0->1 mid-DUMP (after idx=1 transfer) -> out_valid=0 immediately, counters 0, fresh run reaches halt and dumps all 4 words again.
- Saturation: CNT_W=4, mem toggling every cycle for 30 cycles -> chg_cnt and cycle_cnt hold at 15.
